// File: rtl/sop_scanner.sv
// Sequential sum-of-minterms evaluator: latches a 2^N-bit mask on start and
// streams every input row with its function value over a valid/ready handshake.
module sop_scanner #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [(1<<N)-1:0]   truth,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N-1:0]        row,
    output logic                s,
    output logic                busy,
    output logic                done,
    output logic [N:0]          ones_count,
    output logic                is_taut,
    output logic                is_zero
);

    localparam int               ROWS       = 1 << N;
    localparam logic [N-1:0]     LAST_IDX   = N'(ROWS - 1);
    localparam logic [N:0]       FULL_COUNT = (N+1)'(ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [ROWS-1:0] mask_q;
    logic [N-1:0]    idx;
    logic [N:0]      count;
    logic            accept;
    logic            xfer;

    assign accept = (state == IDLE) && start;
    assign xfer   = (state == SCAN) && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (xfer && idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the mask is a flat register vector, so it is reset with everything
    // else; s must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            idx     <= '0;
            count   <= '0;
            is_taut <= 1'b0;
            is_zero <= 1'b0;
        end else begin
            if (accept) begin
                mask_q  <= truth;
                idx     <= '0;
                count   <= '0;
                is_taut <= 1'b0;
                is_zero <= 1'b0;
            end
            if (xfer) begin
                count <= count + {{N{1'b0}}, mask_q[idx]};
                // The terminal row ends the sweep instead of wrapping idx.
                if (idx != LAST_IDX) idx <= idx + N'(1);
            end
            if (state == DONE) begin
                is_taut <= (count == FULL_COUNT);
                is_zero <= (count == '0);
            end
        end
    end

    assign out_valid  = (state == SCAN);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign row        = idx;
    assign s          = mask_q[idx];
    assign ones_count = count;

endmodule

// File: tb/tb_sop_scanner.sv
// Self-checking bench for sop_scanner: N=3 vector table with a row scoreboard,
// plus hand-written sequences for reset abort, N=1 and N=8.
module tb_sop_scanner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // N=3 instance
    logic       start3, rdy3, valid3, s3, busy3, done3, taut3, zero3;
    logic [7:0] truth3;
    logic [2:0] row3;
    logic [3:0] ones3;

    sop_scanner #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .truth(truth3), .out_ready(rdy3),
        .out_valid(valid3), .row(row3), .s(s3), .busy(busy3), .done(done3),
        .ones_count(ones3), .is_taut(taut3), .is_zero(zero3)
    );

    // N=1 instance
    logic       start1, valid1, s1, busy1, done1, taut1, zero1;
    logic [1:0] truth1;
    logic [0:0] row1;
    logic [1:0] ones1;
    logic       rdy_hi = 1'b1;

    sop_scanner #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .truth(truth1), .out_ready(rdy_hi),
        .out_valid(valid1), .row(row1), .s(s1), .busy(busy1), .done(done1),
        .ones_count(ones1), .is_taut(taut1), .is_zero(zero1)
    );

    // N=8 instance
    logic         start8, valid8, s8, busy8, done8, taut8, zero8;
    logic [255:0] truth8;
    logic [7:0]   row8;
    logic [8:0]   ones8;

    sop_scanner #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .truth(truth8), .out_ready(rdy_hi),
        .out_valid(valid8), .row(row8), .s(s8), .busy(busy8), .done(done8),
        .ones_count(ones8), .is_taut(taut8), .is_zero(zero8)
    );

    typedef struct packed {
        logic [2:0] row;
        logic       s;
    } exp_t;

    exp_t sb[$];

    // Each N=3 transfer must match the next expected row in order.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && valid3 && rdy3) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_row", row3, 8);
            end else begin
                e = sb.pop_front();
                check("row3", row3, e.row);
                check("s3", s3, e.s);
            end
        end
    end

    typedef struct {
        logic [7:0] truth;
        logic [3:0] pat;
        bit         poke;
        int         exp_lat;
        int         exp_cnt;
        bit         exp_taut;
        bit         exp_zero;
    } vec_t;

    // Queues the expected rows, starts a sweep and returns the start-to-done
    // latency in cycles; out_ready follows pat cyclically from the first SCAN cycle.
    task automatic run_sweep(input logic [7:0] tr, input logic [3:0] pat,
                             input bit poke, output int lat);
        int k;
        for (int i = 0; i < 8; i++) sb.push_back({3'(i), tr[i]});
        @(posedge clk); #1;
        start3 = 1'b1;
        truth3 = tr;
        @(posedge clk); #1;
        start3 = 1'b0;
        k      = 0;
        lat    = 1;
        rdy3   = pat[0];
        while (!done3 && lat < 100) begin
            @(posedge clk); #1;
            k++;
            lat++;
            rdy3 = pat[k % 4];
            if (poke && lat == 4) begin
                start3 = 1'b1;
                truth3 = 8'h0F;
            end
            if (poke && lat == 6) start3 = 1'b0;
        end
    endtask

    vec_t         vecs[5];
    int           lat;
    int           ones_model;
    bit           saw_done;

    initial begin
        vecs[0] = '{8'hAA, 4'b1111, 1'b0,  9, 4, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 4'b1111, 1'b0,  9, 8, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 4'b1111, 1'b0,  9, 0, 1'b0, 1'b1};
        vecs[3] = '{8'h96, 4'b1001, 1'b0, 17, 4, 1'b0, 1'b0};
        vecs[4] = '{8'hAA, 4'b1111, 1'b1,  9, 4, 1'b0, 1'b0};

        rst_n  = 1'b0;
        start3 = 1'b0; truth3 = '0; rdy3 = 1'b1;
        start1 = 1'b0; truth1 = '0;
        start8 = 1'b0; truth8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid3, 0);
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_row", row3, 0);
        check("rst_s", s3, 0);
        check("rst_ones", ones3, 0);
        check("rst_taut", taut3, 0);
        check("rst_zero", zero3, 0);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            run_sweep(vecs[v].truth, vecs[v].pat, vecs[v].poke, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_ones", v), ones3, vecs[v].exp_cnt);
            check($sformatf("v%0d_rows_left", v), sb.size(), 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_taut", v), taut3, vecs[v].exp_taut);
            check($sformatf("v%0d_zero", v), zero3, vecs[v].exp_zero);
            check($sformatf("v%0d_idle", v), busy3, 0);
        end

        // Asynchronous reset at row 5 aborts the sweep with no done pulse.
        for (int i = 0; i < 8; i++) sb.push_back({3'(i), 1'(i % 2)});
        @(posedge clk); #1;
        start3 = 1'b1; truth3 = 8'hAA; rdy3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 1;
        while (row3 != 3'd5 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("abort_at_row5", row3, 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", valid3, 0);
        check("abort_busy", busy3, 0);
        check("abort_done", done3, 0);
        check("abort_row", row3, 0);
        check("abort_s", s3, 0);
        check("abort_ones", ones3, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done3 || busy3) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        run_sweep(8'hAA, 4'b1111, 1'b0, lat);
        check("post_reset_latency", lat, 9);
        check("post_reset_ones", ones3, 4);

        // N=1: rows 0,1 with s = 0,1.
        @(posedge clk); #1;
        start1 = 1'b1; truth1 = 2'b10;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("n1_valid", valid1, 1);
        check("n1_row0", row1, 0);
        check("n1_s0", s1, 0);
        @(posedge clk); #1;
        check("n1_row1", row1, 1);
        check("n1_s1", s1, 1);
        @(posedge clk); #1;
        check("n1_done", done1, 1);
        check("n1_ones", ones1, 1);

        // N=8: 100 ones scattered via a bijection of 0..255.
        for (int i = 0; i < 256; i++) truth8[i] = ((i * 7) % 256) < 100;
        ones_model = 0;
        @(posedge clk); #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 400) begin
            if (valid8) begin
                check("n8_row", row8, lat - 1);
                check("n8_s", s8, truth8[lat - 1]);
                ones_model += int'(truth8[lat - 1]);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("n8_latency", lat, 257);
        check("n8_ones", ones8, 100);
        check("n8_model_ones", ones_model, 100);
        @(posedge clk); #1;
        check("n8_taut", taut8, 0);
        check("n8_zero", zero8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
